// File: rtl/demux_fifo_pkg.sv
// rtl/demux_fifo_pkg.sv - shared widths, depths and lane indices for the lane demux FIFO
// Contents: DEF_DATA_W / DEF_DEPTH parameter defaults, LANE0 / LANE1 selector encodings.
package demux_fifo_pkg;

  localparam int DEF_DATA_W = 2;
  localparam int DEF_DEPTH  = 4;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

endpackage

// File: rtl/fifo_2bit_sync.sv
// rtl/fifo_2bit_sync.sv - single-clock lane FIFO with push/pop handshake and cleared storage
// Ports:
//   clk      - rising-edge clock
//   reset_L  - synchronous active-low reset, clears pointers, count and storage
//   push     - write data_in this cycle (ignored while full)
//   pop      - remove head this cycle (ignored while empty)
//   data_in  - word to write
//   data_out - head entry, combinational from registered state
//   valid    - FIFO non-empty
//   full     - FIFO holds DEPTH entries
module fifo_2bit_sync
  import demux_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              full
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CNT_W-1:0]  count;

  logic do_push;
  logic do_pop;

  // Both qualifiers use pre-edge state: a push on a full FIFO is refused even if
  // a pop frees a slot at the same edge, and a pop on an empty FIFO is ignored
  // even if a push fills it at the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && valid;

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data_in;
        wr_ptr      <= wr_ptr + 1'b1;   // DEPTH is a power of two, wraps naturally
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign data_out = mem[rd_ptr];
  assign valid    = (count != '0);
  assign full     = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/demux1_2_2bit_fifo.sv
// rtl/demux1_2_2bit_fifo.sv - routes the muxed 2-bit word to one of two buffered lanes
// Ports:
//   clk, reset_L             - clock and synchronous active-low reset
//   data_in, valid_in        - upstream word and push request
//   selector_in              - target lane (LANE0 / LANE1)
//   ready_out                - selected lane can accept a push this cycle
//   laneN_data, laneN_valid  - head entry and non-empty flag of lane N
//   laneN_pop                - consumer removes lane N head this cycle
//   laneN_full               - lane N holds DEPTH entries
//   overflow_err             - sticky, set when a push hits a full lane
module demux1_2_2bit_fifo
  import demux_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  input  logic              selector_in,
  output logic              ready_out,
  output logic [DATA_W-1:0] lane0_data,
  output logic [DATA_W-1:0] lane1_data,
  output logic              lane0_valid,
  output logic              lane1_valid,
  input  logic              lane0_pop,
  input  logic              lane1_pop,
  output logic              lane0_full,
  output logic              lane1_full,
  output logic              overflow_err
);

  logic push_ok;
  logic lane0_push;
  logic lane1_push;

  // Ready follows the selector combinationally, off the registered full flags.
  assign ready_out  = (selector_in == LANE1) ? !lane1_full : !lane0_full;
  assign push_ok    = valid_in && ready_out;
  assign lane0_push = push_ok && (selector_in == LANE0);
  assign lane1_push = push_ok && (selector_in == LANE1);

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      overflow_err <= 1'b0;
    end else if (valid_in && !ready_out) begin
      overflow_err <= 1'b1;
    end
  end

  fifo_2bit_sync #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_lane0 (
    .clk      (clk),
    .reset_L  (reset_L),
    .push     (lane0_push),
    .pop      (lane0_pop),
    .data_in  (data_in),
    .data_out (lane0_data),
    .valid    (lane0_valid),
    .full     (lane0_full)
  );

  fifo_2bit_sync #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_lane1 (
    .clk      (clk),
    .reset_L  (reset_L),
    .push     (lane1_push),
    .pop      (lane1_pop),
    .data_in  (data_in),
    .data_out (lane1_data),
    .valid    (lane1_valid),
    .full     (lane1_full)
  );

endmodule

// File: tb/tb_demux1_2_2bit_fifo.sv
// tb/tb_demux1_2_2bit_fifo.sv - directed vector bench for the lane demux FIFO
module tb_demux1_2_2bit_fifo;

  logic       clk;
  logic       reset_L;
  logic [1:0] data_in;
  logic       valid_in;
  logic       selector_in;
  logic       ready_out;
  logic [1:0] lane0_data;
  logic [1:0] lane1_data;
  logic       lane0_valid;
  logic       lane1_valid;
  logic       lane0_pop;
  logic       lane1_pop;
  logic       lane0_full;
  logic       lane1_full;
  logic       overflow_err;

  demux1_2_2bit_fifo dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .selector_in  (selector_in),
    .ready_out    (ready_out),
    .lane0_data   (lane0_data),
    .lane1_data   (lane1_data),
    .lane0_valid  (lane0_valid),
    .lane1_valid  (lane1_valid),
    .lane0_pop    (lane0_pop),
    .lane1_pop    (lane1_pop),
    .lane0_full   (lane0_full),
    .lane1_full   (lane1_full),
    .overflow_err (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       v;
    logic       s;
    logic [1:0] d;
    logic       p0;
    logic       p1;
    logic       rc;    // check ready_out before the edge
    logic       rdy;
    logic [1:0] l0d;
    logic       l0v;
    logic       l0f;
    logic [1:0] l1d;
    logic       l1v;
    logic       l1f;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];
  int   passed = 0;
  int   total  = 0;

  task automatic add(input logic r, v, s, input logic [1:0] d, input logic p0, p1, rc, rdy,
                     input logic [1:0] l0d, input logic l0v, l0f,
                     input logic [1:0] l1d, input logic l1v, l1f, ovf);
    vec_t t;
    t.r = r; t.v = v; t.s = s; t.d = d; t.p0 = p0; t.p1 = p1; t.rc = rc; t.rdy = rdy;
    t.l0d = l0d; t.l0v = l0v; t.l0f = l0f; t.l1d = l1d; t.l1v = l1v; t.l1f = l1f; t.ovf = ovf;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic drive(input logic r, v, s, input logic [1:0] d, input logic p0, p1);
    reset_L = r; valid_in = v; selector_in = s; data_in = d; lane0_pop = p0; lane1_pop = p1;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

    //   r  v  s  d      p0 p1 rc rdy l0d    v  f  l1d    v  f  ovf
    // reset held two cycles with a push request pending
    add(0, 1, 0, 2'b11, 0, 0, 0, 0,  2'b00, 0, 0, 2'b00, 0, 0, 0);
    add(0, 1, 0, 2'b11, 0, 0, 1, 1,  2'b00, 0, 0, 2'b00, 0, 0, 0);
    // routing
    add(1, 1, 0, 2'b01, 0, 0, 1, 1,  2'b01, 1, 0, 2'b00, 0, 0, 0);
    add(1, 1, 1, 2'b10, 0, 0, 1, 1,  2'b01, 1, 0, 2'b10, 1, 0, 0);
    add(1, 0, 0, 2'b00, 1, 1, 1, 1,  2'b00, 0, 0, 2'b00, 0, 0, 0);
    // fill lane0, overflow, drain in order
    add(1, 1, 0, 2'b00, 0, 0, 1, 1,  2'b00, 1, 0, 2'b00, 0, 0, 0);
    add(1, 1, 0, 2'b01, 0, 0, 1, 1,  2'b00, 1, 0, 2'b00, 0, 0, 0);
    add(1, 1, 0, 2'b10, 0, 0, 1, 1,  2'b00, 1, 0, 2'b00, 0, 0, 0);
    add(1, 1, 0, 2'b11, 0, 0, 1, 1,  2'b00, 1, 1, 2'b00, 0, 0, 0);
    add(1, 1, 0, 2'b01, 0, 0, 1, 0,  2'b00, 1, 1, 2'b00, 0, 0, 1);
    add(1, 0, 1, 2'b00, 0, 0, 1, 1,  2'b00, 1, 1, 2'b00, 0, 0, 1);
    add(1, 0, 0, 2'b00, 1, 0, 1, 0,  2'b01, 1, 0, 2'b00, 0, 0, 1);
    add(1, 0, 0, 2'b00, 1, 0, 1, 1,  2'b10, 1, 0, 2'b00, 0, 0, 1);
    add(1, 0, 0, 2'b00, 1, 0, 1, 1,  2'b11, 1, 0, 2'b00, 0, 0, 1);
    add(1, 0, 0, 2'b00, 1, 0, 1, 1,  2'b00, 0, 0, 2'b00, 0, 0, 1);
    // clear the sticky error, then same-lane push+pop at two entries
    add(0, 0, 0, 2'b00, 0, 0, 1, 1,  2'b00, 0, 0, 2'b00, 0, 0, 0);
    add(1, 1, 0, 2'b10, 0, 0, 1, 1,  2'b10, 1, 0, 2'b00, 0, 0, 0);
    add(1, 1, 0, 2'b11, 0, 0, 1, 1,  2'b10, 1, 0, 2'b00, 0, 0, 0);
    add(1, 1, 0, 2'b01, 1, 0, 1, 1,  2'b11, 1, 0, 2'b00, 0, 0, 0);
    add(1, 0, 0, 2'b00, 1, 0, 1, 1,  2'b01, 1, 0, 2'b00, 0, 0, 0);
    add(1, 0, 0, 2'b00, 1, 0, 1, 1,  2'b00, 0, 0, 2'b00, 0, 0, 0);
    // full lane with push+pop: push refused, pop proceeds
    add(1, 1, 0, 2'b00, 0, 0, 1, 1,  2'b00, 1, 0, 2'b00, 0, 0, 0);
    add(1, 1, 0, 2'b01, 0, 0, 1, 1,  2'b00, 1, 0, 2'b00, 0, 0, 0);
    add(1, 1, 0, 2'b10, 0, 0, 1, 1,  2'b00, 1, 0, 2'b00, 0, 0, 0);
    add(1, 1, 0, 2'b11, 0, 0, 1, 1,  2'b00, 1, 1, 2'b00, 0, 0, 0);
    add(1, 1, 0, 2'b10, 1, 0, 1, 0,  2'b01, 1, 0, 2'b00, 0, 0, 1);
    // lane0 now at 3 entries; fill lane1
    add(1, 1, 1, 2'b11, 0, 0, 1, 1,  2'b01, 1, 0, 2'b11, 1, 0, 1);
    add(1, 1, 1, 2'b10, 0, 0, 1, 1,  2'b01, 1, 0, 2'b11, 1, 0, 1);
    add(1, 1, 1, 2'b01, 0, 0, 1, 1,  2'b01, 1, 0, 2'b11, 1, 0, 1);
    add(1, 1, 1, 2'b00, 0, 0, 1, 1,  2'b01, 1, 0, 2'b11, 1, 1, 1);
    // reset mid-operation dominates push and pop
    add(0, 1, 1, 2'b11, 1, 0, 1, 0,  2'b00, 0, 0, 2'b00, 0, 0, 0);
    add(1, 1, 1, 2'b10, 0, 0, 1, 1,  2'b00, 0, 0, 2'b10, 1, 0, 0);
    add(1, 0, 1, 2'b00, 0, 1, 1, 1,  2'b00, 0, 0, 2'b00, 0, 0, 0);

    foreach (vecs[i]) begin
      vec_t e;
      logic [1:0] m0, m1;
      e = vecs[i];
      @(negedge clk);
      drive(e.r, e.v, e.s, e.d, e.p0, e.p1);
      #1;
      if (e.rc) check($sformatf("vec%0d ready_out", i), {15'd0, ready_out}, {15'd0, e.rdy});
      @(posedge clk);
      #1;
      // head data is only defined while non-empty or straight after reset
      m0 = (e.l0v || !e.r) ? 2'b11 : 2'b00;
      m1 = (e.l1v || !e.r) ? 2'b11 : 2'b00;
      check($sformatf("vec%0d outputs", i),
            {7'd0, lane0_data & m0, lane0_valid, lane0_full, lane1_data & m1, lane1_valid, lane1_full, overflow_err},
            {7'd0, e.l0d & m0, e.l0v, e.l0f, e.l1d & m1, e.l1v, e.l1f, e.ovf});
    end

    // lane1 wrap-around: push each cycle, pop the previous word in the same cycle
    for (int k = 0; k < 10; k++) begin
      logic [1:0] val;
      val = 2'(k % 4);
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b1, val, 1'b0, (k > 0));
      #1;
      check($sformatf("wrap%0d ready_out", k), {15'd0, ready_out}, 16'd1);
      @(posedge clk);
      #1;
      check($sformatf("wrap%0d lane1", k),
            {10'd0, lane1_data, lane1_valid, lane1_full, lane0_valid, overflow_err},
            {10'd0, val, 1'b1, 1'b0, 1'b0, 1'b0});
    end
    // a single pop empties lane1, so occupancy never exceeded one
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("wrap final empty", {14'd0, lane1_valid, overflow_err}, 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/demux1_2_2bit_fifo.md
# demux1_2_2bit_fifo

Downstream companion to the registered 2-bit 2:1 multiplexer stage. Accepts the muxed, flopped 2-bit word plus a lane selector, routes it to one of two output lanes, and buffers each lane in its own small synchronous FIFO so consumers can drain independently with a ready/valid-style pop handshake. Backpressure is returned upstream through a per-cycle ready flag; overflow attempts are dropped and flagged.

## Interface
Parameters:
- DATA_W, 2, width of each data word
- DEPTH, 4, entries per lane FIFO; power of two, ≥2
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset_L  in  1  synchronous, active-low reset; sampled on rising edge of clk
- data_in  in  DATA_W  word from upstream mux stage
- valid_in  in  1  data_in is a push request this cycle
- selector_in  in  1  target lane: 0 → lane0, 1 → lane1
- ready_out  out  1  selected lane can accept a push this cycle
- lane0_data / lane1_data  out  DATA_W  head entry of each lane FIFO
- lane0_valid / lane1_valid  out  1  lane FIFO non-empty
- lane0_pop / lane1_pop  in  1  consumer removes head this cycle
- lane0_full / lane1_full  out  1  lane FIFO holds DEPTH entries
- overflow_err  out  1  sticky: a push hit a full lane

## Operation
- Reset (reset_L=0 at edge): all pointers and counters → 0; laneX_valid=0, laneX_full=0, laneX_data=2'b00, overflow_err=0; FIFO contents cleared to 0. Reset dominates any simultaneous push/pop.
- ready_out = !lane{selector_in}_full (combinational from registered full and selector_in).
- Push: valid_in && ready_out → data_in written at wr_ptr of selected lane, wr_ptr++ (wraps mod DEPTH). Unselected lane untouched.
- Drop: valid_in && !ready_out → no write; overflow_err set to 1, held until reset.
- Pop: laneX_pop && laneX_valid → rd_ptr++ (wraps). Pop on empty lane ignored, no error.
- Simultaneous push and pop, same lane, not full and not empty: both occur, count unchanged.
- Push on full lane with same-cycle pop: push rejected (ready is based on pre-edge full), pop proceeds; overflow_err set.
- Push on empty lane with same-cycle pop: pop ignored, push lands.
- laneX_data = mem[rd_ptr], combinational from registered state; equals 2'b00 when empty after reset, otherwise don't-care when empty.
- laneX_valid = (count≠0); laneX_full = (count==DEPTH).
- Order preserved per lane; no cross-lane ordering guarantee.

## Timing
- Push latency: word pushed at edge N is visible on laneX_data with laneX_valid=1 immediately after edge N (1-cycle).
- Pop takes effect at the edge; next head visible after that edge.
- Full asserts after the edge that writes entry DEPTH; deasserts after the edge of the first pop.
- Throughput: one push (either lane) and one pop per lane per cycle.
- selector_in and valid_in must be stable before the edge; ready_out may change combinationally with selector_in in the same cycle.

## Structure
- Shared package demux_fifo_pkg: DATA_W, DEPTH defaults, lane index constants LANE0=1'b0, LANE1=1'b1.
- One sub-module fifo_2bit_sync (push, pop, data in/out, valid, full, sync active-low reset), instantiated twice; top level holds lane decode, ready_out, and overflow_err.

## Test plan
- Reset: hold reset_L=0 two cycles with valid_in=1 → all outputs 0, no entries written, overflow_err=0.
- Routing: push 2'b01 sel=0, 2'b10 sel=1 → lane0_data=01, lane1_data=10, both valid; pop both → both valid=0.
- Fill/overflow: push 2'b00,01,10,11 to lane0 → lane0_full=1, ready_out=0 for sel=0; fifth push 2'b01 → dropped, overflow_err=1; pops return 00,01,10,11 in order.
- Wrap-around: 10 interleaved push/pop cycles on lane1 with values 0..3 repeating → output sequence matches input, count never exceeds 1, no error.
- Simultaneous: lane0 holds 2 entries, push+pop same cycle → count stays 2, order intact; full lane push+pop → push rejected, overflow_err=1, count DEPTH-1.
- Reset mid-operation: lane0 at 3 entries, lane1 full, overflow_err=1; assert reset_L=0 one cycle → all empty, flags 0, next push appears as sole entry.
